// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the instruction-fetch path.
package uarch_pkg;

    localparam int FETCH_WIDTH     = 2;
    localparam int CPU_ADDR_BITS   = 32;
    localparam int CPU_INST_BITS   = 32;
    localparam int FQ_DEPTH        = 4;
    localparam int MAX_OUTSTANDING = 2;
    localparam logic [CPU_ADDR_BITS-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0]             pc;
        logic [FETCH_WIDTH*CPU_INST_BITS-1:0] insts;
        logic [FETCH_WIDTH-1:0]               slot_val;
    } fetch_packet_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch blocks with single-cycle flush and occupancy count.
module fetch_queue
    import uarch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  fetch_packet_t               push_data,
    input  logic                        pop,
    output fetch_packet_t               head,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_packet_t      mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner: issues block-aligned requests under a credit limit, queues
// responses for decode and drains stale responses after a redirect.
module fetch_unit
    import uarch_pkg::*;
#(
    parameter int FETCH_WIDTH     = uarch_pkg::FETCH_WIDTH,
    parameter int CPU_ADDR_BITS   = uarch_pkg::CPU_ADDR_BITS,
    parameter int CPU_INST_BITS   = uarch_pkg::CPU_INST_BITS,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC = uarch_pkg::RESET_PC,
    parameter int MAX_OUTSTANDING = uarch_pkg::MAX_OUTSTANDING,
    parameter int FQ_DEPTH        = uarch_pkg::FQ_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  imem_req_rdy,
    output logic                                  imem_req_val,
    output logic [CPU_ADDR_BITS-1:0]              imem_req_packet,
    output logic                                  imem_rec_rdy,
    input  logic                                  imem_rec_val,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0]  imem_rec_packet,
    input  logic                                  redirect_val,
    input  logic [CPU_ADDR_BITS-1:0]              redirect_pc,
    input  logic                                  dec_rdy,
    output logic                                  dec_val,
    output fetch_packet_t                         dec_packet
);

    localparam int BLK_BYTES  = FETCH_WIDTH * 4;
    localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int PEND_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W      = $clog2(FQ_DEPTH + 1);
    localparam logic [CPU_ADDR_BITS-1:0] OFF_MASK = CPU_ADDR_BITS'(BLK_BYTES - 1);

    fetch_state_e               state_reg, state_next;
    logic [CPU_ADDR_BITS-1:0]   pc_reg, pc_next;
    logic [OUT_W-1:0]           outstanding_reg, outstanding_next;
    logic [OUT_W-1:0]           drop_reg, drop_next;

    // Pending FIFO keeps the full request PC; block address and slot offset derive from it.
    logic [CPU_ADDR_BITS-1:0]   pend_pc_mem [MAX_OUTSTANDING];
    logic [PEND_PTR_W-1:0]      pend_wr_ptr_reg;
    logic [PEND_PTR_W-1:0]      pend_rd_ptr_reg;
    logic [CPU_ADDR_BITS-1:0]   pend_head_pc;
    logic [SLOT_W-1:0]          pend_head_slot;

    logic                       req_hs;
    logic                       rec_hs;
    logic                       dec_hs;
    logic                       credit_ok;
    logic [FETCH_WIDTH-1:0]     rsp_slot_val;

    logic                       fq_push;
    fetch_packet_t              fq_push_data;
    fetch_packet_t              fq_head;
    logic                       fq_empty;
    logic [CNT_W-1:0]           fq_count;

    function automatic logic [PEND_PTR_W-1:0] pend_inc(input logic [PEND_PTR_W-1:0] p);
        return (p == PEND_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_ok = (outstanding_reg < OUT_W'(MAX_OUTSTANDING)) &&
                       ((int'(outstanding_reg) + int'(fq_count)) < FQ_DEPTH);

    assign imem_req_val    = rst && (state_reg == ST_RUN) && credit_ok;
    assign imem_req_packet = pc_reg & ~OFF_MASK;
    assign imem_rec_rdy    = rst;

    assign req_hs = imem_req_val && imem_req_rdy;
    assign rec_hs = imem_rec_rdy && imem_rec_val;
    assign dec_hs = dec_val && dec_rdy;

    assign pend_head_pc   = pend_pc_mem[pend_rd_ptr_reg];
    assign pend_head_slot = SLOT_W'((pend_head_pc & OFF_MASK) >> 2);

    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot_val
            assign rsp_slot_val[gi] = (gi >= int'(pend_head_slot));
        end
    endgenerate

    always_comb begin
        fq_push_data          = '0;
        fq_push_data.pc       = pend_head_pc & ~OFF_MASK;
        fq_push_data.insts    = imem_rec_packet;
        fq_push_data.slot_val = rsp_slot_val;
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        drop_next        = drop_reg;
        fq_push          = 1'b0;
        outstanding_next = outstanding_reg + OUT_W'(req_hs) - OUT_W'(rec_hs);

        case (state_reg)
            ST_RUN: begin
                fq_push = rec_hs;
            end
            ST_FLUSH: begin
                drop_next = drop_reg - OUT_W'(rec_hs);
                if (drop_reg == OUT_W'(rec_hs)) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase

        if (req_hs) pc_next = (pc_reg & ~OFF_MASK) + CPU_ADDR_BITS'(BLK_BYTES);

        // Everything still in flight after this edge belongs to the old path.
        if (redirect_val) begin
            pc_next    = redirect_pc;
            fq_push    = 1'b0;
            drop_next  = outstanding_next;
            state_next = (outstanding_next != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            pend_wr_ptr_reg <= '0;
            pend_rd_ptr_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            if (req_hs) pend_wr_ptr_reg <= pend_inc(pend_wr_ptr_reg);
            if (rec_hs) pend_rd_ptr_reg <= pend_inc(pend_rd_ptr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) pend_pc_mem[pend_wr_ptr_reg] <= pc_reg;
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_val),
        .push      (fq_push),
        .push_data (fq_push_data),
        .pop       (dec_hs),
        .head      (fq_head),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    assign dec_val    = rst && !fq_empty;
    assign dec_packet = rst ? fq_head : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder, epoch-based reference model,
// directed tables, hand-written corner sequences and a randomized run.
module tb_fetch_unit;
    import uarch_pkg::*;

    localparam int BLK = FETCH_WIDTH * 4;
    localparam int IW  = FETCH_WIDTH * CPU_INST_BITS;

    logic                      clk;
    logic                      rst;
    logic                      imem_req_rdy;
    logic                      imem_req_val;
    logic [CPU_ADDR_BITS-1:0]  imem_req_packet;
    logic                      imem_rec_rdy;
    logic                      imem_rec_val;
    logic [IW-1:0]             imem_rec_packet;
    logic                      redirect_val;
    logic [CPU_ADDR_BITS-1:0]  redirect_pc;
    logic                      dec_rdy;
    logic                      dec_val;
    fetch_packet_t             dec_packet;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_rdy    (imem_req_rdy),
        .imem_req_val    (imem_req_val),
        .imem_req_packet (imem_req_packet),
        .imem_rec_rdy    (imem_rec_rdy),
        .imem_rec_val    (imem_rec_val),
        .imem_rec_packet (imem_rec_packet),
        .redirect_val    (redirect_val),
        .redirect_pc     (redirect_pc),
        .dec_rdy         (dec_rdy),
        .dec_val         (dec_val),
        .dec_packet      (dec_packet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per request accepted by memory, oldest first.
    typedef struct {
        logic [31:0] addr;
        int          k;
        int          epoch;
        logic [31:0] dut_addr;
        int          ready;
    } ent_t;

    ent_t           mq[$];
    fetch_packet_t  fq[$];
    logic [31:0]    mpc;
    int             epoch;
    int             cyc;
    int             lat;
    int             n_vec;
    int             n_bad;

    logic           s_req_val;
    logic [31:0]    s_addr;
    logic           s_rec_rdy;
    logic           s_dec_val;
    fetch_packet_t  s_dec_pkt;

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [IW-1:0] block_insts(input logic [31:0] a);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            r[i*CPU_INST_BITS +: CPU_INST_BITS] = (a + 32'(i * 4)) ^ 32'hC0DE_0000;
        return r;
    endfunction

    function automatic fetch_packet_t make_block(input logic [31:0] a, input int k);
        fetch_packet_t p;
        p.pc    = a;
        p.insts = block_insts(a);
        for (int i = 0; i < FETCH_WIDTH; i++) p.slot_val[i] = (i >= k);
        return p;
    endfunction

    function automatic logic model_req_val();
        logic stale;
        stale = 1'b0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale = 1'b1;
        return !stale && (mq.size() < MAX_OUTSTANDING) && (mq.size() + fq.size() < FQ_DEPTH);
    endfunction

    task automatic tick(input bit rst_v, input bit req_rdy_v, input bit resp_en,
                        input bit dec_rdy_v, input bit redir_v, input logic [31:0] redir_pc_v);
        logic          req_hs;
        logic          rec_hs;
        logic          dec_hs;
        logic          exp_req;
        logic [31:0]   maligned;
        ent_t          e;
        fetch_packet_t dummy;
        @(negedge clk);
        rst          = rst_v;
        imem_req_rdy = req_rdy_v;
        dec_rdy      = dec_rdy_v;
        redirect_val = redir_v;
        redirect_pc  = redir_pc_v;
        if (mq.size() > 0 && mq[0].ready <= cyc && resp_en) begin
            imem_rec_val    = 1'b1;
            imem_rec_packet = block_insts(mq[0].dut_addr);
        end else begin
            imem_rec_val    = 1'b0;
            imem_rec_packet = '0;
        end
        #1;
        s_req_val = imem_req_val;
        s_addr    = imem_req_packet;
        s_rec_rdy = imem_rec_rdy;
        s_dec_val = dec_val;
        s_dec_pkt = dec_packet;
        maligned  = mpc & ~32'(BLK - 1);
        if (!rst_v) begin
            check("rst_req_val", s_req_val, 1'b0);
            check("rst_rec_rdy", s_rec_rdy, 1'b0);
            check("rst_dec_val", s_dec_val, 1'b0);
            check("rst_dec_packet", s_dec_pkt, '0);
        end else begin
            exp_req = model_req_val();
            check("rec_rdy", s_rec_rdy, 1'b1);
            check("req_val", s_req_val, exp_req);
            if (s_req_val && exp_req) check("req_addr", s_addr, maligned);
            check("dec_val", s_dec_val, fq.size() != 0);
            if (s_dec_val && fq.size() != 0) check("dec_packet", s_dec_pkt, fq[0]);
        end
        req_hs = rst_v && s_req_val && req_rdy_v;
        rec_hs = rst_v && s_rec_rdy && imem_rec_val;
        dec_hs = rst_v && s_dec_val && dec_rdy_v;
        @(posedge clk);
        if (!rst_v) begin
            mq.delete();
            fq.delete();
            mpc   = RESET_PC;
            epoch = 0;
        end else begin
            if (dec_hs) begin
                $display("dec  pc=%08h slot_val=%b", s_dec_pkt.pc, s_dec_pkt.slot_val);
                if (fq.size() > 0) dummy = fq.pop_front();
            end
            if (rec_hs && mq.size() > 0) begin
                e = mq.pop_front();
                if (e.epoch == epoch) fq.push_back(make_block(e.addr, e.k));
            end
            if (req_hs) begin
                e.addr     = maligned;
                e.k        = int'((mpc & 32'(BLK - 1)) >> 2);
                e.epoch    = epoch;
                e.dut_addr = s_addr;
                e.ready    = cyc + lat;
                mq.push_back(e);
                mpc = maligned + 32'(BLK);
            end
            if (redir_v) begin
                mpc = redir_pc_v;
                fq.delete();
                epoch++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        lat = 1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        bit          fresh;
        bit          dec_rdy;
        bit          exp_req_val;
        logic [31:0] exp_addr;
        bit          exp_dec_val;
        logic [31:0] exp_dec_pc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] tgt;
        bit          r_rst;
        n_vec = 0; n_bad = 0; cyc = 0; lat = 1; epoch = 0; mpc = RESET_PC;
        rst = 1'b0; imem_req_rdy = 1'b0; imem_rec_val = 1'b0; imem_rec_packet = '0;
        redirect_val = 1'b0; redirect_pc = '0; dec_rdy = 1'b0;

        // Streaming with decode always ready, then back-pressure filling the queue.
        vecs[0]  = '{1, 1, 1, 32'h00, 0, 32'h00};
        vecs[1]  = '{0, 1, 1, 32'h08, 0, 32'h00};
        vecs[2]  = '{0, 1, 1, 32'h10, 1, 32'h00};
        vecs[3]  = '{0, 1, 1, 32'h18, 1, 32'h08};
        vecs[4]  = '{0, 1, 1, 32'h20, 1, 32'h10};
        vecs[5]  = '{1, 0, 1, 32'h00, 0, 32'h00};
        vecs[6]  = '{0, 0, 1, 32'h08, 0, 32'h00};
        vecs[7]  = '{0, 0, 1, 32'h10, 1, 32'h00};
        vecs[8]  = '{0, 0, 1, 32'h18, 1, 32'h00};
        vecs[9]  = '{0, 0, 0, 32'h00, 1, 32'h00};
        vecs[10] = '{0, 0, 0, 32'h00, 1, 32'h00};
        vecs[11] = '{0, 0, 0, 32'h00, 1, 32'h00};
        vecs[12] = '{0, 1, 0, 32'h00, 1, 32'h00};
        vecs[13] = '{0, 1, 1, 32'h20, 1, 32'h08};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].fresh) do_reset();
            tick(1'b1, 1'b1, 1'b1, vecs[i].dec_rdy, 1'b0, 32'h0);
            check($sformatf("tbl%0d_req_val", i), s_req_val, vecs[i].exp_req_val);
            if (vecs[i].exp_req_val) check($sformatf("tbl%0d_req_addr", i), s_addr, vecs[i].exp_addr);
            check($sformatf("tbl%0d_dec_val", i), s_dec_val, vecs[i].exp_dec_val);
            if (vecs[i].exp_dec_val) check($sformatf("tbl%0d_dec_pc", i), s_dec_pkt.pc, vecs[i].exp_dec_pc);
        end

        // Redirect to 0x104 with two requests outstanding.
        do_reset();
        tick(1, 1, 0, 1, 0, 32'h0);
        tick(1, 1, 0, 1, 0, 32'h0);
        tick(1, 1, 0, 1, 1, 32'h104);
        check("redir_credit_stall", s_req_val, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("redir_flush_req0", s_req_val, 1'b0);
        check("redir_flush_dec", s_dec_val, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("redir_flush_req1", s_req_val, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("redir_new_req_val", s_req_val, 1'b1);
        check("redir_new_req_addr", s_addr, 32'h100);
        tick(1, 1, 1, 1, 0, 32'h0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("redir_blk_val", s_dec_val, 1'b1);
        check("redir_blk_pc", s_dec_pkt.pc, 32'h100);
        check("redir_blk_slots", s_dec_pkt.slot_val, 2'b10);

        // Redirect coinciding with a request and a response handshake.
        do_reset();
        tick(1, 1, 1, 1, 0, 32'h0);
        tick(1, 1, 1, 1, 1, 32'h40);
        check("same_cyc_req_hs", s_req_val, 1'b1);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("same_cyc_drop_req", s_req_val, 1'b0);
        check("same_cyc_drop_dec", s_dec_val, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("same_cyc_resume_val", s_req_val, 1'b1);
        check("same_cyc_resume_addr", s_addr, 32'h40);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("same_cyc_no_stale", s_dec_val, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("same_cyc_blk_pc", s_dec_pkt.pc, 32'h40);

        // Reset asserted with two requests outstanding.
        do_reset();
        tick(1, 1, 0, 1, 0, 32'h0);
        tick(1, 1, 0, 1, 0, 32'h0);
        tick(0, 1, 1, 1, 0, 32'h0);
        tick(0, 1, 1, 1, 0, 32'h0);
        check("midrst_rec_rdy", s_rec_rdy, 1'b0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("midrst_restart_val", s_req_val, 1'b1);
        check("midrst_restart_addr", s_addr, RESET_PC);
        check("midrst_dec_val", s_dec_val, 1'b0);

        // Address wrap at the top of the address space.
        do_reset();
        tick(1, 0, 1, 1, 1, 32'hFFFF_FFF0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("wrap_req0", s_addr, 32'hFFFF_FFF0);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("wrap_req1", s_addr, 32'hFFFF_FFF8);
        tick(1, 1, 1, 1, 0, 32'h0);
        check("wrap_req2_val", s_req_val, 1'b1);
        check("wrap_req2_addr", s_addr, 32'h0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lat   = $urandom_range(1, 4);
            r_rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFE0 + 32'(4 * $urandom_range(0, 7));
            else
                tgt = 32'(4 * $urandom_range(0, 255));
            tick(r_rst, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
